// File: rtl/button_conditioner.sv
// Push-button front end: 2-flop sync, debounce, per-channel press/release/long/repeat FSM.
// Level and pulses appear 2+DEBOUNCE_SAMP edges after a raw change; no backpressure, free-running.
module button_conditioner #(
  parameter int N_BTN         = 3,
  parameter int DEBOUNCE_SAMP = 2,
  parameter int REPEAT_DELAY  = 10,
  parameter int REPEAT_PERIOD = 4,
  parameter int LONG_PRESS    = 40
) (
  input  logic             clk_20Hz,
  input  logic             rst,
  input  logic [N_BTN-1:0] i_btn_raw,
  input  logic [N_BTN-1:0] i_repeat_en,
  output logic [N_BTN-1:0] o_btn_level,
  output logic [N_BTN-1:0] o_btn_press,
  output logic [N_BTN-1:0] o_btn_release,
  output logic [N_BTN-1:0] o_btn_long,
  output logic             o_any_press
);

  localparam logic [3:0] LP_DS = DEBOUNCE_SAMP[3:0];
  localparam logic [7:0] LP_RD = REPEAT_DELAY[7:0];
  localparam logic [7:0] LP_RP = REPEAT_PERIOD[7:0];
  localparam logic [7:0] LP_LP = LONG_PRESS[7:0];

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_HELD      = 2'd1,
    ST_REPEATING = 2'd2
  } state_t;

  for (genvar g = 0; g < N_BTN; g++) begin : g_ch
    logic       r_s1, r_s2, r_level;
    logic [3:0] r_dcnt;
    state_t     r_state, w_state_nxt;
    logic [7:0] r_hold, w_hold_nxt, w_hold_inc;
    logic [7:0] r_rep, w_rep_nxt;
    logic       r_long_done, w_long_done_nxt;
    logic       r_press, r_release, r_long;
    logic       w_press_nxt, w_release_nxt, w_long_nxt;
    logic       w_diff, w_toggle, w_rise, w_fall;
    logic       w_hold_step, w_rd_hit, w_rp_hit, w_lp_hit;

    assign w_diff   = (r_s2 != r_level);
    assign w_toggle = w_diff && ((r_dcnt + 4'd1) == LP_DS);
    assign w_rise   = w_toggle && !r_level;
    assign w_fall   = w_toggle && r_level;

    // Saturating hold counter; "becomes X" only counts on a real step.
    assign w_hold_step = (r_hold != 8'hFF);
    assign w_hold_inc  = w_hold_step ? (r_hold + 8'd1) : r_hold;
    assign w_rd_hit    = i_repeat_en[g] && w_hold_step && (w_hold_inc == LP_RD);
    assign w_rp_hit    = i_repeat_en[g] && ((r_rep + 8'd1) == LP_RP);
    assign w_lp_hit    = (r_state != ST_IDLE) && w_hold_step && (w_hold_inc == LP_LP) && !r_long_done;

    always_ff @(posedge clk_20Hz or posedge rst) begin
      if (rst) begin
        r_s1    <= 1'b0;
        r_s2    <= 1'b0;
        r_level <= 1'b0;
        r_dcnt  <= 4'd0;
      end else begin
        r_s1 <= i_btn_raw[g];
        r_s2 <= r_s1;
        if (w_toggle) begin
          r_level <= ~r_level;
          r_dcnt  <= 4'd0;
        end else if (w_diff) begin
          r_dcnt <= r_dcnt + 4'd1;
        end else begin
          r_dcnt <= 4'd0;
        end
      end
    end

    always_ff @(posedge clk_20Hz or posedge rst) begin
      if (rst) begin
        r_state     <= ST_IDLE;
        r_hold      <= 8'd0;
        r_rep       <= 8'd0;
        r_long_done <= 1'b0;
        r_press     <= 1'b0;
        r_release   <= 1'b0;
        r_long      <= 1'b0;
      end else begin
        r_state     <= w_state_nxt;
        r_hold      <= w_hold_nxt;
        r_rep       <= w_rep_nxt;
        r_long_done <= w_long_done_nxt;
        r_press     <= w_press_nxt;
        r_release   <= w_release_nxt;
        r_long      <= w_long_nxt;
      end
    end

    always_comb begin
      w_state_nxt     = r_state;
      w_hold_nxt      = r_hold;
      w_rep_nxt       = r_rep;
      w_long_done_nxt = r_long_done;
      if (w_fall) begin
        w_state_nxt     = ST_IDLE;
        w_hold_nxt      = 8'd0;
        w_rep_nxt       = 8'd0;
        w_long_done_nxt = 1'b0;
      end else begin
        if (w_lp_hit) w_long_done_nxt = 1'b1;
        case (r_state)
          ST_IDLE: begin
            if (w_rise) begin
              w_state_nxt = ST_HELD;
              w_hold_nxt  = 8'd0;
              w_rep_nxt   = 8'd0;
            end
          end
          ST_HELD: begin
            w_hold_nxt = w_hold_inc;
            if (w_rd_hit) begin
              w_state_nxt = ST_REPEATING;
              w_rep_nxt   = 8'd0;
            end
          end
          ST_REPEATING: begin
            w_hold_nxt = w_hold_inc;
            if (!i_repeat_en[g]) w_state_nxt = ST_HELD;
            else if (w_rp_hit)   w_rep_nxt   = 8'd0;
            else                 w_rep_nxt   = r_rep + 8'd1;
          end
          default: w_state_nxt = ST_IDLE;
        endcase
      end
    end

    // Release wins over any press/long on the falling edge.
    always_comb begin
      w_press_nxt   = 1'b0;
      w_release_nxt = 1'b0;
      w_long_nxt    = 1'b0;
      if (w_fall) begin
        w_release_nxt = 1'b1;
      end else begin
        w_long_nxt = w_lp_hit;
        case (r_state)
          ST_IDLE:      w_press_nxt = w_rise;
          ST_HELD:      w_press_nxt = w_rd_hit;
          ST_REPEATING: w_press_nxt = w_rp_hit;
          default:      w_press_nxt = 1'b0;
        endcase
      end
    end

    assign o_btn_level[g]   = r_level;
    assign o_btn_press[g]   = r_press;
    assign o_btn_release[g] = r_release;
    assign o_btn_long[g]    = r_long;
  end

  assign o_any_press = |o_btn_press;

endmodule
